// File: rtl/proc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// proc_ctrl_pkg
// Shared types and constants for the multi-cycle processor control sequencer:
// FSM state encoding, opcode values, ALU function codes and PC source selects.
// No ports.
// -----------------------------------------------------------------------------
package proc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_ERROR
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_LW    = 4'h2;
    localparam logic [3:0] OP_SW    = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_JMP   = 4'h5;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

endpackage

// File: rtl/proc_ctrl_if.sv
// -----------------------------------------------------------------------------
// proc_ctrl_if
// Bundle between the control sequencer and the datapath / memories.
//   master : the sequencer (drives enables, selects, requests, status)
//   slave  : the datapath and memory side (drives decode fields, flags, acks)
// Signals: opcode, fn, alu_zero, instr_ack, mem_ack (datapath -> sequencer);
//          instr_req, ir_load, pc_write, pc_src, alu_op, alu_src, mem_req,
//          mem_we, reg_write, mem_to_reg, halted, bus_err, retired
//          (sequencer -> datapath).
// Build option: PROC_CTRL_TRAP_EN adds the illegal_op status signal.
// -----------------------------------------------------------------------------
interface proc_ctrl_if #(
    parameter int OPCODE_W = 4,
    parameter int FN_W     = 6,
    parameter int ALU_OP_W = 3,
    parameter int CNT_W    = 16
);
    logic [OPCODE_W-1:0] opcode;
    logic [FN_W-1:0]     fn;
    logic                alu_zero;
    logic                instr_ack;
    logic                mem_ack;

    logic                instr_req;
    logic                ir_load;
    logic                pc_write;
    logic [1:0]          pc_src;
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_src;
    logic                mem_req;
    logic                mem_we;
    logic                reg_write;
    logic                mem_to_reg;
    logic                halted;
    logic                bus_err;
    logic [CNT_W-1:0]    retired;
`ifdef PROC_CTRL_TRAP_EN
    logic                illegal_op;
`endif

    modport master (
        input  opcode, fn, alu_zero, instr_ack, mem_ack,
        output instr_req, ir_load, pc_write, pc_src, alu_op, alu_src,
               mem_req, mem_we, reg_write, mem_to_reg, halted, bus_err, retired
`ifdef PROC_CTRL_TRAP_EN
        , output illegal_op
`endif
    );

    modport slave (
        output opcode, fn, alu_zero, instr_ack, mem_ack,
        input  instr_req, ir_load, pc_write, pc_src, alu_op, alu_src,
               mem_req, mem_we, reg_write, mem_to_reg, halted, bus_err, retired
`ifdef PROC_CTRL_TRAP_EN
        , input illegal_op
`endif
    );

endinterface

// File: rtl/proc_ctrl_wdog.sv
// -----------------------------------------------------------------------------
// proc_ctrl_wdog
// Wait-state watchdog for one request/ack handshake. Counts cycles in which
// the request is high without an ack; expire_o flags the cycle that would
// bring the count to TIMEOUT so the sequencer can leave on that same edge.
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   clr_i    hold the count at zero (sequencer not in the owning state)
//   req_i    request currently asserted
//   ack_i    handshake completes this cycle
//   expire_o timeout reached this cycle
// -----------------------------------------------------------------------------
module proc_ctrl_wdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic req_i,
    input  logic ack_i,
    output logic expire_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire_o = req_i && !ack_i && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (req_i && !ack_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/proc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// proc_ctrl_fsm
// Multi-cycle control sequencer for the 16-bit processor datapath. Decodes the
// latched opcode/fn fields, drives every datapath enable and select, and
// handshakes with instruction and data memory, stretching on wait states.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    proc_ctrl_if.master: decode fields, ALU flag, memory acks in;
//          enables, selects, requests, halted/bus_err status, retired count out
// Build option: PROC_CTRL_TRAP_EN -- illegal opcodes (6..E) trap to ERROR and
// set the sticky illegal_op output. Without it they execute as a NOP.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// S_IDLE   | one cycle after reset
// S_FETCH  | instr_req until instr_ack; load IR and PC+1 on ack
// S_DECODE | register read and sign-extend settle, no enables
// S_EXEC   | ALU op by opcode; branch/jump update PC
// S_MEM    | mem_req until mem_ack; address held on the ALU
// S_WB     | register file write (ALU result or load data)
// S_HALT   | terminal, halted=1
// S_ERROR  | terminal, bus_err=1 (or illegal_op=1 with trapping)
// -----------------------------------------------------------------------------
module proc_ctrl_fsm
    import proc_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 4,
    parameter int FN_W        = 6,
    parameter int ALU_OP_W    = 3,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        reset,
    proc_ctrl_if.master bus
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               halted_q, halted_d;
    logic               bus_err_q, bus_err_d;
`ifdef PROC_CTRL_TRAP_EN
    logic               illegal_q, illegal_d;
`endif

    logic               instr_req;
    logic               ir_load;
    logic               pc_write;
    logic [1:0]         pc_src;
    logic [ALU_OP_W-1:0] alu_op;
    logic               alu_src;
    logic               mem_req;
    logic               mem_we;
    logic               reg_write;
    logic               mem_to_reg;
    logic               retire;
    logic               fetch_expire;
    logic               mem_expire;
    logic               unused_fn;

    assign unused_fn = ^bus.fn[FN_W-1:ALU_OP_W];

    // Each watchdog is held cleared outside its state, so it starts from zero
    // on every entry to FETCH or MEM.
    proc_ctrl_wdog #(.TIMEOUT(MEM_TIMEOUT)) u_wdog_fetch (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (state_q != S_FETCH),
        .req_i    (instr_req),
        .ack_i    (bus.instr_ack),
        .expire_o (fetch_expire)
    );

    proc_ctrl_wdog #(.TIMEOUT(MEM_TIMEOUT)) u_wdog_mem (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (state_q != S_MEM),
        .req_i    (mem_req),
        .ack_i    (bus.mem_ack),
        .expire_o (mem_expire)
    );

    always_comb begin
        state_d    = state_q;
        halted_d   = halted_q;
        bus_err_d  = bus_err_q;
`ifdef PROC_CTRL_TRAP_EN
        illegal_d  = illegal_q;
`endif
        instr_req  = 1'b0;
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_INC;
        alu_op     = ALU_ADD;
        alu_src    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        retire     = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                instr_req = 1'b1;
                if (bus.instr_ack) begin
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_INC;
                    state_d  = S_DECODE;
                end else if (fetch_expire) begin
                    bus_err_d = 1'b1;
                    state_d   = S_ERROR;
                end
            end

            S_DECODE: begin
                state_d = S_EXEC;
            end

            S_EXEC: begin
                case (bus.opcode)
                    OP_RTYPE: begin
                        alu_op  = bus.fn[ALU_OP_W-1:0];
                        state_d = S_WB;
                    end
                    OP_ADDI: begin
                        alu_src = 1'b1;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src = 1'b1;
                        state_d = S_MEM;
                    end
                    OP_BEQ: begin
                        alu_op = ALU_SUB;
                        if (bus.alu_zero) begin
                            pc_write = 1'b1;
                            pc_src   = PC_BR;
                        end
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_JMP: begin
                        pc_write = 1'b1;
                        pc_src   = PC_JMP;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    OP_HALT: begin
                        halted_d = 1'b1;
                        retire   = 1'b1;
                        state_d  = S_HALT;
                    end
                    default: begin
`ifdef PROC_CTRL_TRAP_EN
                        illegal_d = 1'b1;
                        state_d   = S_ERROR;
`else
                        retire  = 1'b1;
                        state_d = S_FETCH;
`endif
                    end
                endcase
            end

            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (bus.opcode == OP_SW);
                alu_src = 1'b1;
                if (bus.mem_ack) begin
                    if (bus.opcode == OP_SW) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (mem_expire) begin
                    bus_err_d = 1'b1;
                    state_d   = S_ERROR;
                end
            end

            S_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
                // There is no ALU output register, so the ALU controls from
                // EXEC are kept up for ALU-result writes.
                if (bus.opcode == OP_LW) begin
                    mem_to_reg = 1'b1;
                end else if (bus.opcode == OP_RTYPE) begin
                    alu_op = bus.fn[ALU_OP_W-1:0];
                end else begin
                    alu_src = 1'b1;
                end
            end

            S_HALT, S_ERROR: begin
                state_d = state_q;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        retired_d = retired_q + CNT_W'(retire);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            retired_q <= '0;
            halted_q  <= 1'b0;
            bus_err_q <= 1'b0;
`ifdef PROC_CTRL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            halted_q  <= halted_d;
            bus_err_q <= bus_err_d;
`ifdef PROC_CTRL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    assign bus.instr_req  = instr_req;
    assign bus.ir_load    = ir_load;
    assign bus.pc_write   = pc_write;
    assign bus.pc_src     = pc_src;
    assign bus.alu_op     = alu_op;
    assign bus.alu_src    = alu_src;
    assign bus.mem_req    = mem_req;
    assign bus.mem_we     = mem_we;
    assign bus.reg_write  = reg_write;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.halted     = halted_q;
    assign bus.bus_err    = bus_err_q;
    assign bus.retired    = retired_q;
`ifdef PROC_CTRL_TRAP_EN
    assign bus.illegal_op = illegal_q;
`endif

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_proc_ctrl_fsm
// Directed bench for proc_ctrl_fsm: walks each instruction class through the
// sequencer with hand-computed cycle-by-cycle expectations, then covers async
// reset, fetch/memory timeouts, the retired-counter wrap and illegal opcodes
// (PROC_CTRL_TRAP_EN selects which illegal-opcode behaviour is expected).
// -----------------------------------------------------------------------------
module tb_proc_ctrl_fsm;
    import proc_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    proc_ctrl_if bus ();

    proc_ctrl_fsm dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs and outputs are handled mid-cycle.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [5:0] en_vec();
        return {bus.instr_req, bus.ir_load, bus.pc_write, bus.mem_req, bus.mem_we, bus.reg_write};
    endfunction

    initial begin
        rst_n         = 1'b0;
        bus.opcode    = OP_ADDI;
        bus.fn        = 6'b000101;
        bus.alu_zero  = 1'b0;
        bus.instr_ack = 1'b1;
        bus.mem_ack   = 1'b0;
        #100;
        chk("rst_en", 32'(en_vec()), 0);
        chk("rst_retired", 32'(bus.retired), 0);
        chk("rst_flags", {30'd0, bus.halted, bus.bus_err}, 0);
        rst_n = 1'b1;
        #1;
        chk("idle_req", 32'(bus.instr_req), 0);

        // ADDI, zero-wait fetch
        cyc();
        chk("f1_load", {27'd0, bus.ir_load, bus.pc_write, bus.pc_src, bus.instr_req}, 32'b11001);
        chk("f1_retired", 32'(bus.retired), 0);
        cyc();
        chk("dec_en", 32'(en_vec()), 0);
        cyc();
        chk("addi_alu", {28'd0, bus.alu_src, bus.alu_op}, 32'b1000);
        chk("addi_ex_wr", 32'(bus.reg_write), 0);
        cyc();
        chk("addi_wb", {30'd0, bus.reg_write, bus.mem_to_reg}, 32'b10);
        chk("addi_wb_ret", 32'(bus.retired), 0);
        cyc();
        chk("addi_ret", 32'(bus.retired), 1);
        chk("addi_wb_once", {30'd0, bus.reg_write, bus.ir_load}, 32'b01);

        // LW with three wait states
        bus.opcode = OP_LW;
        cyc();
        cyc();
        chk("lw_ex", {27'd0, bus.mem_req, bus.alu_src, bus.alu_op}, 32'b01000);
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 3) begin
                bus.mem_ack = 1'b1;
                #1;
            end
            chk("lw_mem", {29'd0, bus.mem_req, bus.mem_we, bus.alu_src}, 32'b101);
        end
        cyc();
        bus.mem_ack = 1'b0;
        #1;
        chk("lw_wb", {29'd0, bus.reg_write, bus.mem_to_reg, bus.mem_req}, 32'b110);
        cyc();
        chk("lw_ret", 32'(bus.retired), 2);

        // SW with three wait states: no WB
        bus.opcode = OP_SW;
        cyc();
        cyc();
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 3) begin
                bus.mem_ack = 1'b1;
                #1;
            end
            chk("sw_mem", {30'd0, bus.mem_req, bus.mem_we}, 32'b11);
        end
        cyc();
        bus.mem_ack = 1'b0;
        #1;
        chk("sw_fetch", {30'd0, bus.ir_load, bus.reg_write}, 32'b10);
        chk("sw_ret", 32'(bus.retired), 3);

        // BEQ taken
        bus.opcode   = OP_BEQ;
        bus.alu_zero = 1'b1;
        cyc();
        chk("beq_dec", 32'(bus.pc_write), 0);
        cyc();
        chk("beq_t", {25'd0, bus.pc_write, bus.pc_src, bus.alu_src, bus.alu_op}, 32'b1010001);
        cyc();
        chk("beq_t_ret", {15'd0, bus.instr_req, bus.retired}, {15'd0, 1'b1, 16'd4});

        // BEQ not taken
        bus.alu_zero = 1'b0;
        cyc();
        cyc();
        chk("beq_nt", {28'd0, bus.pc_write, bus.alu_op}, 32'b0001);
        cyc();
        chk("beq_nt_ret", {15'd0, bus.instr_req, bus.retired}, {15'd0, 1'b1, 16'd5});

        // JMP
        bus.opcode = OP_JMP;
        cyc();
        cyc();
        chk("jmp", {29'd0, bus.pc_write, bus.pc_src}, 32'b110);
        cyc();
        chk("jmp_ret", 32'(bus.retired), 6);

        // R-type, fn[2:0] = 3
        bus.opcode = OP_RTYPE;
        bus.fn     = 6'b101011;
        cyc();
        cyc();
        chk("rtype_ex", {28'd0, bus.alu_src, bus.alu_op}, 32'b0011);
        cyc();
        chk("rtype_wb", {27'd0, bus.reg_write, bus.mem_to_reg, bus.alu_op}, 32'b10011);
        cyc();
        chk("rtype_ret", 32'(bus.retired), 7);

        // HALT
        bus.opcode = OP_HALT;
        cyc();
        cyc();
        cyc();
        chk("halt", {29'd0, bus.halted, bus.bus_err, bus.instr_req}, 32'b100);
        chk("halt_ret", 32'(bus.retired), 8);
        cyc();
        chk("halt_stay", {25'd0, bus.halted, en_vec()}, 32'b1000000);

        rst_n = 1'b0;
        #1;
        chk("rst_async", {15'd0, bus.halted, bus.retired}, 0);
        rst_n = 1'b1;
        cyc();

        // Illegal opcode 7
        bus.opcode = 4'h7;
        cyc();
        cyc();
        chk("ill_ex_en", 32'(en_vec()), 0);
        cyc();
`ifdef PROC_CTRL_TRAP_EN
        chk("ill_trap", {29'd0, bus.illegal_op, bus.bus_err, bus.instr_req}, 32'b100);
        chk("ill_trap_ret", 32'(bus.retired), 0);
`else
        chk("ill_nop", {30'd0, bus.instr_req, bus.bus_err}, 32'b10);
        chk("ill_nop_ret", 32'(bus.retired), 1);
`endif

        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        cyc();

        // Reset asserted mid-MEM drops mem_req without a clock edge
        bus.opcode = OP_LW;
        cyc();
        cyc();
        cyc();
        chk("mid_mem", 32'(bus.mem_req), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mem_drop", 32'(bus.mem_req), 0);
        rst_n = 1'b1;
        cyc();

        // Fetch ack on the 16th request cycle still completes
        bus.instr_ack = 1'b0;
        #1;
        for (int i = 0; i < 15; i++) begin
            chk("fwait", {30'd0, bus.instr_req, bus.ir_load}, 32'b10);
            cyc();
        end
        bus.instr_ack = 1'b1;
        #1;
        chk("f16_ack", 32'(bus.ir_load), 1);
        bus.opcode = OP_JMP;
        cyc();
        chk("f16_dec", {30'd0, bus.bus_err, bus.instr_req}, 0);

        // Retired counter wrap
        force dut.retired_q = 16'hFFFF;
        #1;
        release dut.retired_q;
        cyc();
        chk("wrap_jmp", {29'd0, bus.pc_write, bus.pc_src}, 32'b110);
        cyc();
        chk("wrap", 32'(bus.retired), 0);

        // Fetch timeout: 16 request cycles then ERROR
        bus.instr_ack = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) begin
            chk("tmo_req", {30'd0, bus.instr_req, bus.bus_err}, 32'b10);
            cyc();
        end
        chk("tmo_err", {28'd0, bus.bus_err, bus.halted, bus.instr_req, bus.ir_load}, 32'b1000);
`ifdef PROC_CTRL_TRAP_EN
        chk("tmo_no_ill", 32'(bus.illegal_op), 0);
`endif
        bus.instr_ack = 1'b1;
        cyc();
        chk("err_stay", {30'd0, bus.bus_err, bus.instr_req}, 32'b10);

        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        cyc();

        // Memory timeout
        bus.opcode = OP_LW;
        cyc();
        cyc();
        cyc();
        for (int i = 0; i < 16; i++) begin
            chk("mtmo_req", {30'd0, bus.mem_req, bus.bus_err}, 32'b10);
            cyc();
        end
        chk("mtmo_err", {29'd0, bus.bus_err, bus.mem_req, bus.reg_write}, 32'b100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
